// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
// Format codes, opcodes, FSM states, ImmSrc codes and helpers.
package instr_encoder_loader_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMMSRC_I = 2'b00;
  localparam logic [1:0] IMMSRC_B = 2'b01;
  localparam logic [1:0] IMMSRC_S = 2'b10;
  localparam logic [1:0] IMMSRC_J = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ENCODE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // ImmSrc the decoder derives from an opcode
  function automatic logic [1:0] imm_src_of(
    input logic [6:0] op
  );
    logic [1:0] s;
    s = IMMSRC_I;
    unique case (1'b1)
      (op == OP_BRANCH): s = IMMSRC_B;
      (op == OP_STORE):  s = IMMSRC_S;
      (op == OP_JAL):    s = IMMSRC_J;
      default:           s = IMMSRC_I;
    endcase
    return s;
  endfunction

  function automatic logic fmt_legal(
    input logic [2:0] f
  );
    return f <= FMT_J;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer with optional immediate range check.
// IMM_RANGE_CHECK_EN: flag immediates that do not fit their format.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        fmt_bad,
  output logic        range_err
);

  // Assemble the instruction word for the selected format
  always_comb begin
    word    = '0;
    fmt_bad = !fmt_legal(f.fmt);
    unique case (1'b1)
      (f.fmt == FMT_R):
        word = {f.funct7, f.rs2, f.rs1,
                f.funct3, f.rd, f.opcode};
      (f.fmt == FMT_I):
        word = {f.imm[11:0], f.rs1,
                f.funct3, f.rd, f.opcode};
      (f.fmt == FMT_S):
        word = {f.imm[11:5], f.rs2, f.rs1,
                f.funct3, f.imm[4:0], f.opcode};
      (f.fmt == FMT_B):
        word = {f.imm[12], f.imm[10:5],
                f.rs2, f.rs1, f.funct3,
                f.imm[4:1], f.imm[11], f.opcode};
      (f.fmt == FMT_U):
        word = {f.imm[31:12], f.rd, f.opcode};
      (f.fmt == FMT_J):
        word = {f.imm[20], f.imm[10:1],
                f.imm[11], f.imm[19:12],
                f.rd, f.opcode};
      default:
        word = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = f.imm;

  // Flag immediates that would lose bits when packed
  always_comb begin
    range_err = 1'b0;
    unique case (1'b1)
      (f.fmt == FMT_I),
      (f.fmt == FMT_S):
        range_err = (simm < -32'sd2048)
                  || (simm > 32'sd2047);
      (f.fmt == FMT_B):
        range_err = (simm < -32'sd4096)
                  || (simm > 32'sd4094)
                  || f.imm[0];
      (f.fmt == FMT_U):
        range_err = (f.imm[11:0] != 12'd0);
      (f.fmt == FMT_J):
        range_err = (simm < -32'sd1048576)
                  || (simm > 32'sd1048574)
                  || f.imm[0];
      default:
        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs RV32I field bundles and writes them to instruction memory.
// IMM_RANGE_CHECK_EN enables immediate range checking in the packer.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C =
    DEPTH[ADDR_W:0];

  state_e      state;
  state_e      state_nx;
  fields_t     fld;
  logic        last_q;
  logic [31:0] word;
  logic        fmt_bad;
  logic        range_err;
  logic        full;
  logic        enc_err;

  instr_field_packer u_packer (
    .f         (fld),
    .word      (word),
    .fmt_bad   (fmt_bad),
    .range_err (range_err)
  );

  assign full    = (count == DEPTH_C);
  assign enc_err = fmt_bad | full | range_err;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (start) state_nx = ST_ACCEPT;
      ST_ACCEPT:
        if (in_valid) state_nx = ST_ENCODE;
      ST_ENCODE:
        state_nx = enc_err ? ST_DONE : ST_WRITE;
      ST_WRITE:
        state_nx = last_q ? ST_DONE : ST_ACCEPT;
      ST_DONE:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  // Per-state outputs
  always_comb begin
    in_ready = (state == ST_ACCEPT);
    mem_we   = (state == ST_WRITE);
    busy     = (state == ST_ACCEPT)
            || (state == ST_ENCODE)
            || (state == ST_WRITE);
  end

  // Session datapath: capture, encode, address/count, flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fld       <= '0;
      last_q    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            mem_addr <= base_addr;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            fld <= '{fmt:    fmt,
                     opcode: opcode,
                     rd:     rd,
                     rs1:    rs1,
                     rs2:    rs2,
                     funct3: funct3,
                     funct7: funct7,
                     imm:    imm};
            last_q <= in_last;
          end
        end
        ST_ENCODE: begin
          if (enc_err) begin
            err  <= 1'b1;
            done <= 1'b1;
          end else begin
            mem_wdata <= word;
          end
        end
        ST_WRITE: begin
          count    <= count + 1'b1;
          mem_addr <= mem_addr + 1'b1;
          if (last_q) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader.
// Model: per-session address/count tracking and expected write queue.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int AW = 8;
  localparam int DP = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_last = 0;
  logic [2:0]    fmt = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  instr_encoder_loader #(
    .ADDR_W(AW),
    .DEPTH (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  logic [7:0]  m_addr;
  int          m_count;
  bit          m_err;
  bit          m_over;
  logic [31:0] last_wdata = '0;
  logic [7:0]  last_addr = '0;
  int          n_writes = 0;

  // Reference encoding from the RV32I bit layout, built with shifts
  function automatic logic [31:0] model_pack(
    input int f, input int op, input int rdv,
    input int r1, input int r2, input int f3,
    input int f7, input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] base_rs;
    base_rs = (r2 << 20) | (r1 << 15) | (f3 << 12);
    case (f)
      0: w = (f7 << 25) | base_rs | (rdv << 7) | op;
      1: w = ((im & 32'hFFF) << 20) | (r1 << 15)
           | (f3 << 12) | (rdv << 7) | op;
      2: w = (((im >> 5) & 32'h7F) << 25) | base_rs
           | ((im & 32'h1F) << 7) | op;
      3: w = (((im >> 12) & 1) << 31)
           | (((im >> 5) & 32'h3F) << 25) | base_rs
           | (((im >> 1) & 32'hF) << 8)
           | (((im >> 11) & 1) << 7) | op;
      4: w = (im & 32'hFFFFF000) | (rdv << 7) | op;
      5: w = (((im >> 20) & 1) << 31)
           | (((im >> 1) & 32'h3FF) << 21)
           | (((im >> 11) & 1) << 20)
           | (((im >> 12) & 32'hFF) << 12)
           | (rdv << 7) | op;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit range_bad(input int f,
                                   input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = im;
    case (f)
      1, 2: return (s < -2048) || (s > 2047);
      3: return (s < -4096) || (s > 4094) || im[0];
      4: return im[11:0] != 0;
      5: return (s < -1048576) || (s > 1048574) || im[0];
      default: return 0;
    endcase
`else
    return (f < 0) && (im == 0);
`endif
  endfunction

  // Cycle-accurate write monitor against the expected queue
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("mem_we", mem_we, 1);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.data);
      last_wdata = mem_wdata;
      last_addr  = mem_addr;
      n_writes++;
    end else begin
      chk("mem_we_idle", mem_we, 0);
    end
  end

  task automatic start_session(input logic [7:0] b);
    @(negedge clk);
    start = 1;
    base_addr = b;
    @(negedge clk);
    start = 0;
    m_addr = b;
    m_count = 0;
    m_err = 0;
    m_over = 0;
    chk("start_err_clr", err, 0);
    chk("start_cnt_clr", count, 0);
    chk("start_busy", busy, 1);
  endtask

  task automatic send(input int f, input int op,
                      input int rdv, input int r1,
                      input int r2, input int f3,
                      input int f7, input logic [31:0] im,
                      input bit last, input int gap);
    bit ok;
    exp_t e;
    repeat (gap) @(negedge clk);
    fmt = f[2:0];
    opcode = op[6:0];
    rd = rdv[4:0];
    rs1 = r1[4:0];
    rs2 = r2[4:0];
    funct3 = f3[2:0];
    funct7 = f7[6:0];
    imm = im;
    in_last = last;
    in_valid = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("handshake_timeout", 0, 1);
      in_valid = 0;
      m_over = 1;
      return;
    end
    if (f > 5 || m_count == DP || range_bad(f, im)) begin
      m_err = 1;
      m_over = 1;
    end else begin
      e.cyc = cyc + 2;
      e.addr = m_addr;
      e.data = model_pack(f, op, rdv, r1, r2, f3, f7, im);
      q.push_back(e);
      m_addr = m_addr + 1;
      m_count++;
      if (last) m_over = 1;
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 12; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("err", err, m_err);
    chk("count", count, m_count);
    chk("busy_at_done", busy, 0);
    chk("ready_at_done", in_ready, 0);
  endtask

  function automatic logic [31:0] rand_imm(input int f);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 5) == 0) return r;
    case (f)
      1, 2: return {{20{r[11]}}, r[11:0]};
      3: return {{19{r[12]}}, r[12:1], 1'b0};
      4: return r & 32'hFFFFF000;
      5: return {{11{r[20]}}, r[20:1], 1'b0};
      default: return r;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0",
             cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int nb, f, sw;
    logic [31:0] im;

    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    rst_n = 1;

    chk("pin_addi", model_pack(1, 7'h13, 1, 0, 0, 0, 0, 5),
        32'h00500093);
    chk("pin_beq", model_pack(3, 7'h63, 0, 0, 0, 0, 0,
        -32'sd4), 32'hFE000EE3);

    // addi x1, x0, 5
    start_session(0);
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 1, 0);
    wait_done();
    chk("addi_word", last_wdata, 32'h00500093);
    chk("addi_addr", last_addr, 0);
    chk("addi_count", count, 1);
    @(negedge clk);
    chk("done_sticky", done, 1);

    // sw then beq
    start_session(0);
    send(2, 7'h23, 0, 0, 2, 2, 0, 8, 0, 0);
    chk("sw_word", q[0].data, 32'h00202423);
    send(3, 7'h63, 0, 0, 0, 0, 0, -32'sd4, 1, 0);
    wait_done();
    chk("beq_word", last_wdata, 32'hFE000EE3);
    chk("beq_addr", last_addr, 1);

    // jal x1, 8
    start_session(0);
    send(5, 7'h6F, 1, 0, 0, 0, 0, 8, 1, 0);
    wait_done();
    chk("jal_word", last_wdata, 32'h008000EF);
    chk("jal_immsrc", imm_src_of(last_wdata[6:0]), 2'b11);

    // illegal format
    sw = n_writes;
    start_session(0);
    send(7, 7'h13, 1, 0, 0, 0, 0, 0, 1, 0);
    wait_done();
    chk("ill_err", err, 1);
    chk("ill_nowrite", n_writes, sw);
    start_session(0);
    send(1, 7'h13, 2, 0, 0, 0, 0, 1, 1, 0);
    wait_done();

    // full: five bundles, only four written
    sw = n_writes;
    start_session(8'd10);
    for (int i = 0; i < 5; i++)
      if (!m_over)
        send(1, 7'h13, i, 0, 0, 0, 0, i, i == 4, 0);
    wait_done();
    chk("full_writes", n_writes - sw, 4);
    chk("full_err", err, 1);
    chk("full_last_addr", last_addr, 13);

    // address wrap
    start_session(8'd255);
    send(4, 7'h37, 3, 0, 0, 0, 0, 32'h12345000, 0, 1);
    send(4, 7'h37, 4, 0, 0, 0, 0, 32'hABCDE000, 1, 0);
    wait_done();
    chk("wrap_addr", last_addr, 0);
    chk("wrap_word", last_wdata, 32'hABCDE237);

    // immediate outside the I range
    start_session(0);
    send(1, 7'h13, 1, 0, 0, 0, 0, 4096, 1, 0);
    wait_done();
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_err", err, 1);
`else
    chk("trunc_word", last_wdata, 32'h00000093);
`endif

    // reset between accept and write
    start_session(0);
    send(1, 7'h13, 5, 6, 0, 0, 0, 7, 1, 0);
    rst_n = 0;
    void'(q.pop_back());
    @(negedge clk);
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_count", count, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_ready", in_ready, 0);
    rst_n = 1;

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      start_session(8'($urandom));
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        if (m_over) break;
        f = ($urandom_range(0, 9) == 0)
          ? $urandom_range(6, 7)
          : $urandom_range(0, 5);
        im = rand_imm(f);
        send(f, $urandom_range(0, 127),
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7),
             $urandom_range(0, 127), im,
             i == nb - 1, $urandom_range(0, 2));
      end
      wait_done();
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
